// File: rtl/csr_stage.sv
// Machine-mode CSR stage: CSR read/modify/write, ECALL/MRET redirects and
// machine-timer interrupt entry, all results registered for writeback.
module csr_stage #(
  parameter int FMAX_MHz = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] reg_cycle,
  input  logic [63:0] reg_time,
  input  logic [63:0] reg_mtime,
  input  logic [63:0] reg_mtimecmp,
  input  logic        wb_branch_hazard,
  input  logic [2:0]  input_csr_cmd,
  input  logic [31:0] input_op1_data,
  input  logic [31:0] input_imm_i,
  input  logic        input_interrupt_ready,
  input  logic [31:0] if_reg_pc,
  output logic [2:0]  output_csr_cmd,
  output logic [31:0] csr_rdata,
  output logic [31:0] trap_vector,
  output logic        output_stall_flg_may_interrupt
);

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_W     = 3'd1;
  localparam logic [2:0] CMD_S     = 3'd2;
  localparam logic [2:0] CMD_C     = 3'd3;
  localparam logic [2:0] CMD_ECALL = 3'd4;
  localparam logic [2:0] CMD_MRET  = 3'd5;

  logic        r_mie;
  logic        r_mpie;
  logic        r_mtie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [2:0]  r_out_cmd;
  logic [31:0] r_rdata;
  logic [31:0] r_trap_vector;

  logic [11:0] w_addr;
  logic [2:0]  w_cmd;
  logic        w_timer_hit;
  logic        w_pending;
  logic        w_take_irq;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_unused;

  assign w_addr      = input_imm_i[11:0];
  assign w_unused    = &{1'b0, input_imm_i[31:12]};
  assign w_timer_hit = (reg_mtime >= reg_mtimecmp);
  assign w_pending   = r_mie & r_mtie & w_timer_hit;
  assign w_take_irq  = w_pending & input_interrupt_ready & (w_cmd == CMD_NONE) & ~wb_branch_hazard;

  // Flushed commands and the undefined encodings 6/7 both behave as NONE.
  always_comb begin
    w_cmd = input_csr_cmd;
    if (wb_branch_hazard || input_csr_cmd > CMD_MRET) begin
      w_cmd = CMD_NONE;
    end
  end

  always_comb begin
    w_old = 32'd0;
    case (w_addr)
      12'h300: w_old = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
      12'h304: w_old = {24'd0, r_mtie, 7'd0};
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h344: w_old = {24'd0, w_timer_hit, 7'd0};
      12'hC00, 12'hB00: w_old = reg_cycle[31:0];
      12'hC80, 12'hB80: w_old = reg_cycle[63:32];
      12'hC01: w_old = reg_time[31:0];
      12'hC81: w_old = reg_time[63:32];
      12'hFC0: w_old = 32'(FMAX_MHz);
      default: w_old = 32'd0;
    endcase
  end

  always_comb begin
    w_new = w_old;
    case (w_cmd)
      CMD_W:   w_new = input_op1_data;
      CMD_S:   w_new = w_old | input_op1_data;
      CMD_C:   w_new = w_old & ~input_op1_data;
      default: w_new = w_old;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_mtie        <= 1'b0;
      r_mtvec       <= 32'd0;
      r_mscratch    <= 32'd0;
      r_mepc        <= 32'd0;
      r_mcause      <= 32'd0;
      r_out_cmd     <= CMD_NONE;
      r_rdata       <= 32'd0;
      r_trap_vector <= 32'd0;
    end else begin
      case (w_cmd)
        CMD_W, CMD_S, CMD_C: begin
          r_out_cmd <= w_cmd;
          r_rdata   <= w_old;
          // Only the RW addresses latch; read-only and unmapped ones drop the write.
          case (w_addr)
            12'h300: begin
              r_mie  <= w_new[3];
              r_mpie <= w_new[7];
            end
            12'h304: r_mtie     <= w_new[7];
            12'h305: r_mtvec    <= w_new;
            12'h340: r_mscratch <= w_new;
            12'h341: r_mepc     <= w_new;
            12'h342: r_mcause   <= w_new;
            default: ;
          endcase
        end
        CMD_ECALL: begin
          r_out_cmd     <= CMD_ECALL;
          r_rdata       <= 32'd0;
          r_mcause      <= 32'd11;
          r_trap_vector <= r_mtvec;
        end
        CMD_MRET: begin
          r_out_cmd     <= CMD_MRET;
          r_rdata       <= 32'd0;
          r_trap_vector <= r_mepc;
          r_mie         <= r_mpie;
          r_mpie        <= 1'b1;
        end
        default: begin
          r_rdata <= 32'd0;
          if (w_take_irq) begin
            r_out_cmd     <= CMD_ECALL;
            r_mepc        <= if_reg_pc;
            r_mcause      <= 32'h8000_0007;
            r_mpie        <= r_mie;
            r_mie         <= 1'b0;
            r_trap_vector <= r_mtvec;
          end else begin
            r_out_cmd <= CMD_NONE;
          end
        end
      endcase
    end
  end

  assign output_csr_cmd                 = r_out_cmd;
  assign csr_rdata                      = r_rdata;
  assign trap_vector                    = r_trap_vector;
  assign output_stall_flg_may_interrupt = w_pending;

endmodule

// File: tb/tb_csr_stage.sv
// Directed bench for csr_stage: CSR RMW, ECALL/MRET, timer interrupt entry,
// flush squashing, read-only CSRs and reset during a qualifying interrupt.
module tb_csr_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] reg_cycle, reg_time, reg_mtime, reg_mtimecmp;
  logic        wb_branch_hazard;
  logic [2:0]  input_csr_cmd;
  logic [31:0] input_op1_data, input_imm_i;
  logic        input_interrupt_ready;
  logic [31:0] if_reg_pc;
  logic [2:0]  output_csr_cmd;
  logic [31:0] csr_rdata, trap_vector;
  logic        output_stall_flg_may_interrupt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  csr_stage #(.FMAX_MHz(27)) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .reg_cycle                      (reg_cycle),
    .reg_time                       (reg_time),
    .reg_mtime                      (reg_mtime),
    .reg_mtimecmp                   (reg_mtimecmp),
    .wb_branch_hazard               (wb_branch_hazard),
    .input_csr_cmd                  (input_csr_cmd),
    .input_op1_data                 (input_op1_data),
    .input_imm_i                    (input_imm_i),
    .input_interrupt_ready          (input_interrupt_ready),
    .if_reg_pc                      (if_reg_pc),
    .output_csr_cmd                 (output_csr_cmd),
    .csr_rdata                      (csr_rdata),
    .trap_vector                    (trap_vector),
    .output_stall_flg_may_interrupt (output_stall_flg_may_interrupt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock with the given command; outputs settle 1 ns after the edge.
  task automatic op(input logic [2:0] cmd, input logic [11:0] addr, input logic [31:0] op1);
    input_csr_cmd  = cmd;
    input_imm_i    = {20'hABCDE, addr};
    input_op1_data = op1;
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%0b cmd=%0d addr=%h op1=%h haz=%0b rdy=%0b -> ocmd=%0d rdata=%h trap=%h stall=%0b",
             $time, rst_n, cmd, addr, op1, wb_branch_hazard, input_interrupt_ready,
             output_csr_cmd, csr_rdata, trap_vector, output_stall_flg_may_interrupt);
  endtask

  initial begin
    rst_n = 1'b0;
    reg_cycle = 64'h0000_0005_0000_0009;
    reg_time  = 64'h0000_0012_0000_0034;
    reg_mtime = 64'd0;
    reg_mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
    wb_branch_hazard = 1'b0;
    input_interrupt_ready = 1'b0;
    if_reg_pc = 32'h0;
    input_csr_cmd = 3'd0; input_op1_data = 0; input_imm_i = 0;

    op(3'd1, 12'h340, 32'h55);  // write during reset is ignored
    op(3'd0, 12'h000, 32'h0);
    check("rst_cmd",   32'(output_csr_cmd), 32'd0);
    check("rst_rdata", csr_rdata, 32'd0);
    check("rst_trap",  trap_vector, 32'd0);
    check("rst_stall", 32'(output_stall_flg_may_interrupt), 32'd0);
    rst_n = 1'b1;

    op(3'd2, 12'h340, 32'h0);
    check("rst_mscratch", csr_rdata, 32'd0);

    // mtvec write then set
    op(3'd1, 12'h305, 32'h8000_0100);
    check("w_cmd",  32'(output_csr_cmd), 32'd1);
    check("w_old",  csr_rdata, 32'd0);
    op(3'd2, 12'h305, 32'h3);
    check("s_cmd",  32'(output_csr_cmd), 32'd2);
    check("s_old",  csr_rdata, 32'h8000_0100);
    op(3'd2, 12'h305, 32'h0);
    check("mtvec",  csr_rdata, 32'h8000_0103);
    op(3'd3, 12'h305, 32'h1);
    check("c_old",  csr_rdata, 32'h8000_0103);
    op(3'd2, 12'h305, 32'h0);
    check("c_new",  csr_rdata, 32'h8000_0102);
    op(3'd1, 12'h305, 32'h8000_0103);

    // MRET and ECALL
    op(3'd1, 12'h341, 32'h1234);
    op(3'd5, 12'h000, 32'h0);
    check("mret_cmd",  32'(output_csr_cmd), 32'd5);
    check("mret_trap", trap_vector, 32'h1234);
    op(3'd2, 12'h300, 32'h0);
    check("mret_mstatus", csr_rdata, 32'h80);
    op(3'd4, 12'h000, 32'h0);
    check("ecall_cmd",  32'(output_csr_cmd), 32'd4);
    check("ecall_trap", trap_vector, 32'h8000_0103);
    op(3'd2, 12'h342, 32'h0);
    check("ecall_mcause", csr_rdata, 32'd11);
    op(3'd2, 12'h341, 32'h0);
    check("ecall_mepc", csr_rdata, 32'h1234);
    op(3'd0, 12'h341, 32'h0);
    check("none_cmd",   32'(output_csr_cmd), 32'd0);
    check("none_rdata", csr_rdata, 32'd0);
    check("none_trap",  trap_vector, 32'h8000_0103);
    op(3'd7, 12'h341, 32'hFF);
    check("cmd7_cmd",   32'(output_csr_cmd), 32'd0);

    // Flushed write
    wb_branch_hazard = 1'b1;
    op(3'd1, 12'h340, 32'hDEAD);
    check("haz_cmd", 32'(output_csr_cmd), 32'd0);
    wb_branch_hazard = 1'b0;
    op(3'd2, 12'h340, 32'h0);
    check("haz_mscratch", csr_rdata, 32'd0);

    // Read-only counters and unmapped addresses
    op(3'd2, 12'hC80, 32'h0);  check("cycleh",  csr_rdata, 32'd5);
    op(3'd2, 12'hB00, 32'h0);  check("mcycle",  csr_rdata, 32'd9);
    op(3'd2, 12'hC81, 32'h0);  check("timeh",   csr_rdata, 32'h12);
    op(3'd2, 12'hC01, 32'h0);  check("time",    csr_rdata, 32'h34);
    op(3'd2, 12'hFC0, 32'h0);  check("fmax",    csr_rdata, 32'd27);
    op(3'd1, 12'hC00, 32'hFFFF);
    op(3'd2, 12'hC00, 32'h0);  check("cycle_ro", csr_rdata, 32'd9);
    op(3'd1, 12'h123, 32'hFFFF);
    op(3'd2, 12'h123, 32'h0);  check("unmapped", csr_rdata, 32'd0);
    op(3'd1, 12'h300, 32'hFFFF_FFFF);
    op(3'd2, 12'h300, 32'h0);  check("mstatus_mask", csr_rdata, 32'h88);

    // Timer interrupt
    op(3'd1, 12'h300, 32'h0);
    op(3'd1, 12'h305, 32'h400);
    reg_mtime = 64'd98; reg_mtimecmp = 64'd99;
    op(3'd1, 12'h300, 32'h8);
    op(3'd1, 12'h304, 32'hFFFF_FFFF);
    op(3'd2, 12'h304, 32'h0);  check("mie_mask", csr_rdata, 32'h80);
    check("stall_lt", 32'(output_stall_flg_may_interrupt), 32'd0);
    op(3'd2, 12'h344, 32'h0);  check("mip_lt", csr_rdata, 32'h0);
    reg_mtime = 64'd99;
    op(3'd2, 12'h344, 32'h0);  check("mip_eq", csr_rdata, 32'h80);
    reg_mtime = 64'd100;
    op(3'd0, 12'h000, 32'h0);
    check("pend_stall", 32'(output_stall_flg_may_interrupt), 32'd1);
    check("pend_notrap", 32'(output_csr_cmd), 32'd0);
    input_interrupt_ready = 1'b1;
    if_reg_pc = 32'h200;
    op(3'd2, 12'h340, 32'h0);
    check("prio_cmd", 32'(output_csr_cmd), 32'd2);
    check("prio_stall", 32'(output_stall_flg_may_interrupt), 32'd1);
    op(3'd0, 12'h000, 32'h0);
    check("irq_cmd",   32'(output_csr_cmd), 32'd4);
    check("irq_trap",  trap_vector, 32'h400);
    check("irq_stall", 32'(output_stall_flg_may_interrupt), 32'd0);
    input_interrupt_ready = 1'b0;
    op(3'd2, 12'h341, 32'h0);  check("irq_mepc",    csr_rdata, 32'h200);
    op(3'd2, 12'h342, 32'h0);  check("irq_mcause",  csr_rdata, 32'h8000_0007);
    op(3'd2, 12'h300, 32'h0);  check("irq_mstatus", csr_rdata, 32'h80);

    // Reset during an interrupt-qualifying cycle
    op(3'd1, 12'h300, 32'h8);
    check("rearm_stall", 32'(output_stall_flg_may_interrupt), 32'd1);
    input_interrupt_ready = 1'b1;
    if_reg_pc = 32'h300;
    rst_n = 1'b0;
    op(3'd0, 12'h000, 32'h0);
    check("rst2_cmd",   32'(output_csr_cmd), 32'd0);
    check("rst2_rdata", csr_rdata, 32'd0);
    check("rst2_trap",  trap_vector, 32'd0);
    check("rst2_stall", 32'(output_stall_flg_may_interrupt), 32'd0);
    rst_n = 1'b1;
    input_interrupt_ready = 1'b0;
    op(3'd2, 12'h341, 32'h0);  check("rst2_mepc", csr_rdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_stage.md
CSR_STAGE -- requirements
Module: csr_stage

Interface
REQ-001 Parameter FMAX_MHz, default 27; core clock frequency in MHz, readable via CSR 0xFC0.
REQ-002 clk  in  1  the single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 reg_cycle, reg_time, reg_mtime, reg_mtimecmp  in  64 each  external counters and timer compare value.
REQ-005 wb_branch_hazard  in  1  pipeline flush; squashes the incoming command.
REQ-006 input_csr_cmd  in  3  0 NONE, 1 W, 2 S, 3 C, 4 ECALL, 5 MRET; 6-7 treated as NONE.
REQ-007 input_op1_data  in  32  write/set/clear operand.
REQ-008 input_imm_i  in  32  CSR address is bits [11:0].
REQ-009 input_interrupt_ready  in  1  high when all downstream pipeline stages hold NOPs.
REQ-010 if_reg_pc  in  32  PC held by fetch; saved as mepc on interrupt.
REQ-011 output_csr_cmd  out  3  registered command for writeback (4 = trap redirect, 5 = return redirect).
REQ-012 csr_rdata  out  32  registered old value of the addressed CSR.
REQ-013 trap_vector  out  32  registered redirect target.
REQ-014 output_stall_flg_may_interrupt  out  1  combinational; stalls fetch while an interrupt is pending.

Function
REQ-015 Implemented RW CSRs: mstatus 0x300 (bits 3 MIE, 7 MPIE only; others read 0), mie 0x304 (bit 7 MTIE only), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
REQ-016 Read-only CSRs: cycle 0xC00/mcycle 0xB00 = reg_cycle[31:0]; cycleh 0xC80/mcycleh 0xB80 = reg_cycle[63:32]; time 0xC01 = reg_time[31:0]; timeh 0xC81 = reg_time[63:32]; mip 0x344 = bit 7 set iff reg_mtime >= reg_mtimecmp (unsigned 64-bit); 0xFC0 = FMAX_MHz; writes ignored.
REQ-017 Unimplemented addresses read 0; writes ignored.
REQ-018 Effective command = NONE when wb_branch_hazard is 1, else input_csr_cmd.
REQ-019 W: new = op1; S: new = old | op1; C: new = old & ~op1; written at the clock edge; csr_rdata <= old value (one-cycle latency).
REQ-020 ECALL: mcause <= 11; trap_vector <= current mtvec; output_csr_cmd <= 4; mepc unchanged.
REQ-021 MRET: trap_vector <= current mepc; MIE <= MPIE; MPIE <= 1; output_csr_cmd <= 5.
REQ-022 NONE: output_csr_cmd <= 0, csr_rdata <= 0, trap_vector unchanged.
REQ-023 Pending = MIE & MTIE & (reg_mtime >= reg_mtimecmp); output_stall_flg_may_interrupt = Pending.
REQ-024 Interrupt taken when Pending & input_interrupt_ready & effective command NONE & !wb_branch_hazard: mepc <= if_reg_pc; mcause <= 0x80000007; MPIE <= MIE; MIE <= 0; trap_vector <= mtvec; output_csr_cmd <= 4.
REQ-025 A non-NONE effective command has priority over interrupt entry; the interrupt is taken on a later qualifying cycle.
REQ-026 Taking the interrupt clears MIE, so the stall drops the next cycle.
REQ-027 mtvec writes store the full 32 bits; mtvec is used unmodified (direct mode).

Reset
REQ-028 When rst_n = 0 at a clock edge: all RW CSRs <= 0; output_csr_cmd, csr_rdata, trap_vector <= 0; reset overrides any command or interrupt in that cycle.
REQ-029 After reset, output_stall_flg_may_interrupt = 0 because MIE = 0.

Verification
REQ-030 Write 0x305 with op1 0x80000100 (W), then S with op1 0x3 -> second cycle csr_rdata 0x80000100; a later read returns 0x80000103.
REQ-031 Write mepc 0x1234 then MRET -> trap_vector 0x1234, output_csr_cmd 5; ECALL -> mcause 11, trap_vector = mtvec, output_csr_cmd 4.
REQ-032 mstatus 0x8, mie 0x80, mtime 100, mtimecmp 99, interrupt_ready 0 -> stall 1, no trap; interrupt_ready 1, if_reg_pc 0x200 -> mepc 0x200, mcause 0x80000007, mstatus 0x80, output_csr_cmd 4, stall 0 next cycle.
REQ-033 W to mscratch with wb_branch_hazard 1 -> mscratch unchanged, output_csr_cmd 0.
REQ-034 Read 0xC80 with reg_cycle 0x00000005_00000009 -> csr_rdata 5; read 0xFC0 -> 27; W to 0xC00 -> no effect.
REQ-035 Assert rst_n = 0 during an interrupt-qualifying cycle -> all outputs 0, mepc unchanged at 0.
